// File: rtl/conv_window_gen_pkg.sv
// rtl/conv_window_gen_pkg.sv - shared state type, default geometry and width helper for conv_window_gen
package conv_window_gen_pkg;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        EMIT     = 2'd1,
        LOAD_ROW = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_SIMD       = 8;
    localparam int DEF_IFM_CH     = 16;
    localparam int DEF_IFM_DIM    = 8;
    localparam int DEF_K          = 3;

    localparam int CF        = DEF_IFM_CH / DEF_SIMD;
    localparam int OFM_DIM   = DEF_IFM_DIM - DEF_K + 1;
    localparam int ROW_WORDS = DEF_IFM_DIM * CF;
    localparam int BUF_DEPTH = DEF_K * ROW_WORDS;
    localparam int ADDR_W    = $clog2(BUF_DEPTH);

    // Counter/address width that never collapses to zero bits for tiny geometries.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_window_gen_skid.sv
// rtl/conv_window_gen_skid.sv - 2-entry output buffer for line-buffer read data
// Ports: clk/rst_n (async active-low); push_valid/push_data from the RAM read
// pipeline; out_valid/out_data/out_ready downstream stream; almost_full/full
// report occupancy remaining after this cycle's pop, for read issue control.
module conv_window_gen_skid #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             almost_full,
    output logic             full
);

    logic [WIDTH-1:0] ent_q [2];
    logic [WIDTH-1:0] ent_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [1:0]       occ_after;
    logic             pop;

    always_comb begin
        ent_d    = ent_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop      = out_ready && (count_q != 2'd0);
        if (push_valid) begin
            ent_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_valid} - {1'b0, pop};
        // Occupancy once this cycle's pop has left, ignoring the push landing now;
        // the caller adds its own in-flight read on top of this.
        occ_after   = count_q - {1'b0, pop};
        almost_full = (occ_after != 2'd0);
        full        = (occ_after == 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            ent_q    <= ent_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = ent_q[rd_ptr_q];

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - K-row line buffer emitting KxKxIFM_CH im2col windows as a SIMD stream
// Ports: ap_clk, ap_rst_n (async active-low); in0_V_* raster pixel stream in,
// cf fastest; out_V_* window beats out in oy, ox, ky, kx, cf order.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SIMD       = DEF_SIMD,
    parameter int IFM_CH     = DEF_IFM_CH,
    parameter int IFM_DIM    = DEF_IFM_DIM,
    parameter int K          = DEF_K
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic [DATA_WIDTH*SIMD-1:0] in0_V_TDATA,
    input  logic                       in0_V_TVALID,
    output logic                       in0_V_TREADY,
    output logic [DATA_WIDTH*SIMD-1:0] out_V_TDATA,
    output logic                       out_V_TVALID,
    input  logic                       out_V_TREADY
);

    localparam int N_CF    = IFM_CH / SIMD;
    localparam int N_OFM   = IFM_DIM - K + 1;
    localparam int N_ROW   = IFM_DIM * N_CF;
    localparam int N_DEPTH = K * N_ROW;
    localparam int W       = cnt_width(N_DEPTH);
    localparam int DW      = DATA_WIDTH * SIMD;

    localparam logic [W-1:0] ONE       = W'(1);
    localparam logic [W-1:0] CF_LAST   = W'(N_CF - 1);
    localparam logic [W-1:0] K_LAST    = W'(K - 1);
    localparam logic [W-1:0] OFM_LAST  = W'(N_OFM - 1);
    localparam logic [W-1:0] ROW_LAST  = W'(N_ROW - 1);
    localparam logic [W-1:0] FILL_LAST = W'(N_DEPTH - 1);
    localparam logic [W-1:0] ROW_W     = W'(N_ROW);
    localparam logic [W-1:0] CF_W      = W'(N_CF);
    localparam logic [W-1:0] K_W       = W'(K);

    state_e         state_q, state_d;
    logic [W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [W-1:0]   base_q, base_d;
    logic [W-1:0]   oy_q, oy_d, ox_q, ox_d;
    logic [W-1:0]   ky_q, ky_d, kx_q, kx_d;
    logic [W-1:0]   cf_q, cf_d;
    logic           in_ready_q, in_ready_d;
    logic           rd_valid_q, rd_valid_d;
    logic [DW-1:0]  rd_data_q;
    logic [DW-1:0]  line_mem [N_DEPTH];

    logic           in_fire, wr_en, issue;
    logic [W-1:0]   wr_addr, rd_addr, slot;
    logic           skid_afull, skid_full;

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        base_d   = base_q;
        oy_d     = oy_q;
        ox_d     = ox_q;
        ky_d     = ky_q;
        kx_d     = kx_q;
        cf_d     = cf_q;
        wr_en    = 1'b0;
        issue    = 1'b0;
        in_fire  = in0_V_TVALID && in_ready_q;

        slot = base_q + ky_q;
        if (slot >= K_W) begin
            slot = slot - K_W;
        end
        rd_addr = slot * ROW_W + (ox_q + kx_q) * CF_W + cf_q;
        wr_addr = (state_q == LOAD_ROW) ? (base_q * ROW_W + wr_cnt_q) : wr_cnt_q;

        case (state_q)
            FILL: begin
                if (in_fire) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == FILL_LAST) begin
                        wr_cnt_d = '0;
                        state_d  = EMIT;
                    end else begin
                        wr_cnt_d = wr_cnt_q + ONE;
                    end
                end
            end
            LOAD_ROW: begin
                if (in_fire) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == ROW_LAST) begin
                        wr_cnt_d = '0;
                        base_d   = (base_q == K_LAST) ? '0 : base_q + ONE;
                        oy_d     = oy_q + ONE;
                        state_d  = EMIT;
                    end else begin
                        wr_cnt_d = wr_cnt_q + ONE;
                    end
                end
            end
            EMIT: begin
                // The read issued now lands in the skid two edges later, so it
                // must be counted together with the one already in flight.
                if (!skid_full && !(skid_afull && rd_valid_q)) begin
                    issue = 1'b1;
                    if (cf_q == CF_LAST) begin
                        cf_d = '0;
                        if (kx_q == K_LAST) begin
                            kx_d = '0;
                            if (ky_q == K_LAST) begin
                                ky_d = '0;
                                if (ox_q == OFM_LAST) begin
                                    ox_d = '0;
                                    if (oy_q == OFM_LAST) begin
                                        oy_d    = '0;
                                        base_d  = '0;
                                        state_d = FILL;
                                    end else begin
                                        state_d = LOAD_ROW;
                                    end
                                end else begin
                                    ox_d = ox_q + ONE;
                                end
                            end else begin
                                ky_d = ky_q + ONE;
                            end
                        end else begin
                            kx_d = kx_q + ONE;
                        end
                    end else begin
                        cf_d = cf_q + ONE;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        rd_valid_d = issue;
        in_ready_d = (state_d != EMIT);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= FILL;
            wr_cnt_q   <= '0;
            base_q     <= '0;
            oy_q       <= '0;
            ox_q       <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            cf_q       <= '0;
            in_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            base_q     <= base_d;
            oy_q       <= oy_d;
            ox_q       <= ox_d;
            ky_q       <= ky_d;
            kx_q       <= kx_d;
            cf_q       <= cf_d;
            in_ready_q <= in_ready_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Simple dual-port line buffer; a slot is only rewritten after all of its
    // reads have been captured, so read/write ordering never matters.
    always_ff @(posedge ap_clk) begin
        if (wr_en) begin
            line_mem[wr_addr] <= in0_V_TDATA;
        end
        if (issue) begin
            rd_data_q <= line_mem[rd_addr];
        end
    end

    conv_window_gen_skid #(.WIDTH(DW)) u_skid (
        .clk         (ap_clk),
        .rst_n       (ap_rst_n),
        .push_valid  (rd_valid_q),
        .push_data   (rd_data_q),
        .out_valid   (out_V_TVALID),
        .out_data    (out_V_TDATA),
        .out_ready   (out_V_TREADY),
        .almost_full (skid_afull),
        .full        (skid_full)
    );

    assign in0_V_TREADY = in_ready_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - self-checking bench for conv_window_gen (default and K=1 geometries)
module tb_conv_window_gen;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid, in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] k1_in_data;
    logic          k1_in_valid, k1_in_ready;
    logic [DW-1:0] k1_out_data;
    logic          k1_out_valid, k1_out_ready;

    always #5 clk = ~clk;

    conv_window_gen dut (
        .ap_clk       (clk),
        .ap_rst_n     (rst_n),
        .in0_V_TDATA  (in_data),
        .in0_V_TVALID (in_valid),
        .in0_V_TREADY (in_ready),
        .out_V_TDATA  (out_data),
        .out_V_TVALID (out_valid),
        .out_V_TREADY (out_ready)
    );

    conv_window_gen #(.DATA_WIDTH(8), .SIMD(8), .IFM_CH(8), .IFM_DIM(4), .K(1)) dut_k1 (
        .ap_clk       (clk),
        .ap_rst_n     (rst_n),
        .in0_V_TDATA  (k1_in_data),
        .in0_V_TVALID (k1_in_valid),
        .in0_V_TREADY (k1_in_ready),
        .out_V_TDATA  (k1_out_data),
        .out_V_TVALID (k1_out_valid),
        .out_V_TREADY (k1_out_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_last_fill;
    int first_valid_cyc;
    logic [DW-1:0] frame [128];
    logic [DW-1:0] exp_q [$];
    int lane0_ref [18] = '{0, 1, 2, 3, 4, 5, 16, 17, 18, 19, 20, 21, 32, 33, 34, 35, 36, 37};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic gen_frame();
        for (int n = 0; n < 128; n++) begin
            frame[n] = {$urandom, $urandom};
            frame[n][7:0] = 8'(n);
        end
        for (int oy = 0; oy < 6; oy++)
            for (int ox = 0; ox < 6; ox++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        for (int cf = 0; cf < 2; cf++)
                            exp_q.push_back(frame[((oy + ky) * 8 + ox + kx) * 2 + cf]);
    endtask

    task automatic drive_frame(input int max_beats, input bit gaps, input bit exact);
        int n = 0;
        int guard = 0;
        int zero_run = 0;
        bit pending = 1'b0;
        bit acc;
        while (n < max_beats && guard < 20000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = frame[n];
            @(negedge clk);
            acc = in_valid && in_ready;
            if (in_ready && pending) begin
                checks++;
                if (exact ? (zero_run != 108) : (zero_run < 108)) begin
                    errors++;
                    $display("FAIL emit_tready_low cycles %0d required %0d (exact=%0d)", zero_run, 108, exact);
                end
                pending = 1'b0;
            end else if (!in_ready) begin
                zero_run++;
            end
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                if (n == 47) t_last_fill = cyc;
                if (n >= 47 && (n - 47) % 16 == 0) begin
                    pending  = 1'b1;
                    zero_run = 0;
                end
                n++;
            end
        end
        in_valid = 1'b0;
        if (n < max_beats) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout accepted %0d required %0d", n, max_beats);
        end
        if (pending && max_beats == 128) begin
            guard = 0;
            @(negedge clk);
            while (!in_ready && guard < 20000) begin
                zero_run++;
                guard++;
                @(negedge clk);
            end
            checks++;
            if (exact ? (zero_run != 108) : (zero_run < 108)) begin
                errors++;
                $display("FAIL last_emit_tready_low cycles %0d required %0d (exact=%0d)", zero_run, 108, exact);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic collect(input int num, input bit rand_ready, input bit consts);
        int got = 0;
        int guard = 0;
        bit hold = 1'b0;
        logic [DW-1:0] held, exp_v;
        first_valid_cyc = -1;
        while (got < num && guard < 20000) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++;
                    $display("FAIL stall_hold got %h valid %b required %h valid 1", out_data, out_valid, held);
                end
                hold = 1'b0;
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat index %0d got %h required none", got, out_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (out_data !== exp_v) begin
                        errors++;
                        $display("FAIL window_beat index %0d got %h required %h", got, out_data, exp_v);
                    end
                end
                if (consts && got < 18) begin
                    checks++;
                    if (out_data[7:0] !== 8'(lane0_ref[got])) begin
                        errors++;
                        $display("FAIL lane0_start index %0d got %0d required %0d", got, out_data[7:0], lane0_ref[got]);
                    end
                end
                if (consts && got == 630) begin
                    checks++;
                    if (out_data[7:0] !== 8'd90) begin
                        errors++;
                        $display("FAIL last_window_lane0 got %0d required 90", out_data[7:0]);
                    end
                end
                got++;
            end else if (out_valid === 1'b1) begin
                hold = 1'b1;
                held = out_data;
            end
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b1;
        if (got < num) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout got %0d beats required %0d", got, num);
        end
    endtask

    task automatic run_frame(input bit gaps, input bit rand_ready, input bit exact);
        int extra = 0;
        gen_frame();
        fork
            drive_frame(128, gaps, exact);
            collect(648, rand_ready, 1'b1);
        join
        checks++;
        if (first_valid_cyc != t_last_fill + 2) begin
            errors++;
            $display("FAIL first_out_latency got cycle %0d required %0d", first_valid_cyc, t_last_fill + 2);
        end
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b0) extra++;
        end
        @(posedge clk); #1;
        checks++;
        if (extra != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_beat_count extra %0d pending %0d required 0 and 0", extra, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        k1_in_valid = 1'b0;
        k1_in_data = '0;
        k1_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b required 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h required 0", out_data); end
        if (k1_in_ready !== 1'b0) begin errors++; $display("FAIL reset_k1_in_ready got %b required 0", k1_in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_first_frame();
        run_frame(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_frame(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random_ready();
        run_frame(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_input_gaps();
        run_frame(1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_emit();
        gen_frame();
        fork
            drive_frame(96, 1'b0, 1'b1);
            collect(3 * 108 + 40, 1'b0, 1'b0);
        join
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b required 0", out_valid); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in_ready got %b required 0", in_ready); end
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        run_frame(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_k1();
        logic [DW-1:0] kq [$];
        fork
            begin
                int sent = 0;
                int g = 0;
                bit acc;
                while (sent < 16 && g < 5000) begin
                    k1_in_valid = ($urandom_range(0, 2) != 0);
                    if (k1_in_valid) k1_in_data = {$urandom, $urandom};
                    @(negedge clk);
                    acc = k1_in_valid && k1_in_ready;
                    @(posedge clk); #1;
                    g++;
                    if (acc) begin
                        kq.push_back(k1_in_data);
                        sent++;
                    end
                end
                k1_in_valid = 1'b0;
            end
            begin
                int got = 0;
                int g = 0;
                logic [DW-1:0] e;
                while (got < 16 && g < 5000) begin
                    k1_out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (k1_out_valid === 1'b1 && k1_out_ready) begin
                        checks++;
                        if (kq.size() == 0) begin
                            errors++;
                            $display("FAIL k1_extra_beat index %0d got %h required none", got, k1_out_data);
                        end else begin
                            e = kq.pop_front();
                            if (k1_out_data !== e) begin
                                errors++;
                                $display("FAIL k1_beat index %0d got %h required %h", got, k1_out_data, e);
                            end
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    g++;
                end
                k1_out_ready = 1'b1;
                checks++;
                if (got != 16) begin
                    errors++;
                    $display("FAIL k1_beat_count got %0d required 16", got);
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_random_ready();
        test_input_gaps();
        test_reset_mid_emit();
        test_k1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Sliding-window generator placed directly upstream of the Conv2D core. It accepts a raster-order feature-map stream (SIMD channels per beat), buffers K rows on chip, and emits the K×K×IFM_CH im2col window for every output pixel as a SIMD-wide AXI Stream. Its output feeds the conv core's `in0_V` port unchanged.

## Interface
- DATA_WIDTH, 8, bits per channel element
- SIMD, 8, channels per stream beat
- IFM_CH, 16, input channels; must be a multiple of SIMD; CF = IFM_CH/SIMD
- IFM_DIM, 8, square input height/width
- K, 3, square kernel size; stride 1, no padding; OFM_DIM = IFM_DIM-K+1
- ap_clk  in  1  clock, all logic rising-edge
- ap_rst_n  in  1  reset, asynchronous assert, active-low
- in0_V_TDATA  in  DATA_WIDTH*SIMD  input pixel beat, lane i = channel cf*SIMD+i
- in0_V_TVALID  in  1  input beat valid
- in0_V_TREADY  out  1  block accepts input
- out_V_TDATA  out  DATA_WIDTH*SIMD  window beat
- out_V_TVALID  out  1  output beat valid
- out_V_TREADY  in  1  downstream accepts

## Operation
- Line buffer: single simple-dual-port RAM, depth K*IFM_DIM*CF, width DATA_WIDTH*SIMD, synchronous 1-cycle read; K row slots of IFM_DIM*CF words.
- Input order: y, x, cf (cf fastest). Output order per window: ky, kx, cf; windows in oy, ox order.
- FSM states: FILL, EMIT, LOAD_ROW.
- FILL: in0_V_TREADY=1; accept K*IFM_DIM*CF beats into slots 0..K-1; base slot=0, oy=0; on final beat → EMIT.
- EMIT: issue one read per cycle when skid buffer not full; address = ((base+ky) mod K)*IFM_DIM*CF + (ox+kx)*CF + cf; counters cf→kx→ky→ox nest; OFM_DIM*K*K*CF reads per output row. On issue of final read: if oy=OFM_DIM-1 → FILL (next frame), else → LOAD_ROW.
- LOAD_ROW: in0_V_TREADY=1; accept IFM_DIM*CF beats into slot base, then base=(base+1) mod K, oy+1, → EMIT.
- Output skid buffer: 2 entries, holds read data; out_V_TVALID = buffer non-empty; read issue counts in-flight read against capacity, so no beat is dropped.
- Reads in flight at a state change drain normally; a newly written word never collides with a pending read (reads capture data the cycle after issue).
- in0_V_TREADY is 0 in EMIT; out_V_TVALID may be 1 in FILL/LOAD_ROW while buffer drains.

## Timing
- Reset (async, ap_rst_n=0): state=FILL, all counters 0, base=0, skid buffer empty; in0_V_TREADY=0, out_V_TVALID=0, out_V_TDATA=0 while in reset; in0_V_TREADY=1 first cycle after deassert.
- Reset mid-frame discards buffered data and partial windows; no output beat after reset until a full FILL completes.
- in0_V_TREADY is a registered function of state only; handshake on TVALID&TREADY at rising edge.
- Latency: final FILL handshake at edge t → first read issued cycle t+1 → out_V_TVALID high after edge t+2.
- Throughput in EMIT with out_V_TREADY=1: one output beat per cycle, no bubbles.
- out_V_TDATA/TVALID hold stable while TVALID=1 and TREADY=0.
- Per frame: K*IFM_DIM*CF + (OFM_DIM-1)*IFM_DIM*CF input beats = full frame; OFM_DIM²*K²*CF output beats.

## Structure
- Package conv_window_gen_pkg: state enum (FILL, EMIT, LOAD_ROW), localparams CF, OFM_DIM, ROW_WORDS, BUF_DEPTH, address width via $clog2.
- Sub-module conv_window_gen_skid: 2-entry valid/ready buffer with almost-full output for read issue control.
- RAM inferred in top module.

## Test plan
- Defaults, lane0 of input beat n = n mod 256, out_V_TREADY=1: first 18 output beats lane0 = 0,1,2,3,4,5,16,17,18,19,20,21,32,33,34,35,36,37; first output 2 cycles after input beat 47.
- Full frame: 128 input beats → exactly 648 output beats; last window starts lane0=(5*8+5)*2=90; next frame repeats identical sequence.
- Random out_V_TREADY (50%): output sequence identical to scenario 1, no duplicates or drops, TDATA stable during stalls.
- Random in0_V_TVALID gaps: output sequence unchanged; in0_V_TREADY=0 throughout every EMIT.
- Assert ap_rst_n=0 mid-EMIT of row oy=3: out_V_TVALID drops immediately, in0_V_TREADY=0; after release a fresh frame yields scenario-1 sequence.
- K=1, IFM_DIM=4, CF=1: output equals input stream beat-for-beat (16 beats).
